// File: rtl/pair_diff_sequencer.sv
// rtl/pair_diff_sequencer.sv - pairwise abs-difference / wrapping-sum sequencer between source and result memories
module pair_diff_sequencer #(
    parameter int DATA_W = 8,
    parameter int A_AW   = 3,
    parameter int B_AW   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_mode,
    output logic [A_AW-1:0]   o_a_addr,
    input  logic [DATA_W-1:0] i_a_rd_data,
    output logic              o_b_we,
    output logic [B_AW-1:0]   o_b_addr,
    output logic [DATA_W-1:0] o_b_wr_data,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [B_AW-1:0] LAST_PAIR = {B_AW{1'b1}};

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_reg_a;
    logic [DATA_W-1:0] r_reg_b;
    logic              r_mode;
    logic [A_AW-1:0]   r_a_addr;
    logic [B_AW-1:0]   r_cnt;
    logic [B_AW-1:0]   r_b_addr;
    logic [DATA_W-1:0] r_b_wr_data;
    logic [DATA_W-1:0] w_result;
    logic              w_write;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state control outputs
    always_comb begin
        w_next = r_state;
        w_write = 1'b0;
        o_busy  = 1'b1;
        o_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = S_LOAD_A;
                end
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_WRITE;
            S_WRITE: begin
                w_write = 1'b1;
                w_next  = (r_cnt == LAST_PAIR) ? S_DONE : S_LOAD_A;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Pair result: unsigned absolute difference or sum with carry dropped
    always_comb begin
        w_result = '0;
        if (r_mode) begin
            w_result = r_reg_a + r_reg_b;
        end else if (r_reg_a >= r_reg_b) begin
            w_result = r_reg_a - r_reg_b;
        end else begin
            w_result = r_reg_b - r_reg_a;
        end
    end

    // Operand fetch, address sequencing and hold copies of the last write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_a     <= '0;
            r_reg_b     <= '0;
            r_mode      <= 1'b0;
            r_a_addr    <= '0;
            r_cnt       <= '0;
            r_b_addr    <= '0;
            r_b_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode   <= i_mode;
                        r_a_addr <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_LOAD_A: begin
                    r_reg_a  <= i_a_rd_data;
                    r_a_addr <= r_a_addr + A_AW'(1);
                end
                S_LOAD_B: begin
                    r_reg_b  <= i_a_rd_data;
                    r_a_addr <= r_a_addr + A_AW'(1);
                end
                S_WRITE: begin
                    r_b_addr    <= r_cnt;
                    r_b_wr_data <= w_result;
                    if (r_cnt != LAST_PAIR) begin
                        r_cnt <= r_cnt + B_AW'(1);
                    end
                end
                S_DONE: begin
                    r_a_addr <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // The write port shows live values in WRITE and holds the last write otherwise
    assign o_b_we      = w_write;
    assign o_b_addr    = w_write ? r_cnt : r_b_addr;
    assign o_b_wr_data = w_write ? w_result : r_b_wr_data;
    assign o_a_addr    = r_a_addr;

endmodule

// File: tb/tb_pair_diff_sequencer.sv
// tb/tb_pair_diff_sequencer.sv - directed and randomized self-checking bench for pair_diff_sequencer
`timescale 1ns/1ps
module tb_pair_diff_sequencer;

    logic       clk;
    logic       reset;
    logic       i_start;
    logic       i_mode;
    logic [2:0] o_a_addr;
    logic [7:0] i_a_rd_data;
    logic       o_b_we;
    logic [1:0] o_b_addr;
    logic [7:0] o_b_wr_data;
    logic       o_busy;
    logic       o_done;

    logic [7:0] mem_a [0:7];

    logic       obs_we   [1:32];
    logic [1:0] obs_ba   [1:32];
    logic [7:0] obs_bd   [1:32];
    logic       obs_busy [1:32];
    logic       obs_done [1:32];
    logic [2:0] obs_aa   [1:32];

    int errors;
    int checks;

    pair_diff_sequencer #(
        .DATA_W(8),
        .A_AW  (3),
        .B_AW  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_mode     (i_mode),
        .o_a_addr   (o_a_addr),
        .i_a_rd_data(i_a_rd_data),
        .o_b_we     (o_b_we),
        .o_b_addr   (o_b_addr),
        .o_b_wr_data(o_b_wr_data),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    assign i_a_rd_data = mem_a[o_a_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] model_res(input logic [7:0] a, input logic [7:0] b, input logic m);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (m) return s[7:0];
        if (a >= b) return a - b;
        return b - a;
    endfunction

    // Called at a negedge (cycle 0, IDLE): starts a pass and records cycles 1..ncyc.
    task automatic run_cycles(input logic md, input logic hold, input int ncyc, input int rst_cyc);
        i_mode  = md;
        i_start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            obs_we[c]   = o_b_we;
            obs_ba[c]   = o_b_addr;
            obs_bd[c]   = o_b_wr_data;
            obs_busy[c] = o_busy;
            obs_done[c] = o_done;
            obs_aa[c]   = o_a_addr;
            i_start = hold && (c < ncyc - 1);
            i_mode  = ~md;
            reset   = (c == rst_cyc);
        end
        i_start = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        i_start = 1'b1;
        i_mode  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_a_addr, o_b_addr, o_b_wr_data, o_b_we, o_busy, o_done} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: a_addr=%0d b_addr=%0d b_wr_data=%0d b_we=%b busy=%b done=%b, required all 0",
                     o_a_addr, o_b_addr, o_b_wr_data, o_b_we, o_busy, o_done);
        end
        reset   = 1'b0;
        i_start = 1'b0;
        i_mode  = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b, required 0", o_busy);
        end
    endtask

    task automatic test_absdiff;
        logic [7:0] exp_d [0:3];
        logic [2:0] exp_aa [1:13];
        mem_a[0] = 8'd10;  mem_a[1] = 8'd3; mem_a[2] = 8'd5; mem_a[3] = 8'd9;
        mem_a[4] = 8'd0;   mem_a[5] = 8'd0; mem_a[6] = 8'd255; mem_a[7] = 8'd1;
        exp_d[0] = 8'd7; exp_d[1] = 8'd4; exp_d[2] = 8'd0; exp_d[3] = 8'd254;
        exp_aa[1] = 3'd0; exp_aa[2] = 3'd1; exp_aa[3] = 3'd2; exp_aa[4] = 3'd2;
        exp_aa[5] = 3'd3; exp_aa[6] = 3'd4; exp_aa[7] = 3'd4; exp_aa[8] = 3'd5;
        exp_aa[9] = 3'd6; exp_aa[10] = 3'd6; exp_aa[11] = 3'd7; exp_aa[12] = 3'd0;
        exp_aa[13] = 3'd0;
        run_cycles(1'b0, 1'b0, 13, 0);
        for (int c = 1; c <= 13; c++) begin
            checks++;
            if (obs_we[c] !== (c % 3 == 0 && c <= 12)) begin
                errors++;
                $display("FAIL absdiff_we cycle %0d: got %b", c, obs_we[c]);
            end
            checks++;
            if (obs_busy[c] !== 1'b1 || obs_done[c] !== (c == 13)) begin
                errors++;
                $display("FAIL absdiff_busy_done cycle %0d: busy=%b done=%b, required busy=1 done=%b",
                         c, obs_busy[c], obs_done[c], c == 13);
            end
            checks++;
            if (obs_aa[c] !== exp_aa[c]) begin
                errors++;
                $display("FAIL absdiff_a_addr cycle %0d: got %0d, required %0d", c, obs_aa[c], exp_aa[c]);
            end
            if (c % 3 == 0 && c <= 12) begin
                checks++;
                if (obs_ba[c] !== 2'(c / 3 - 1) || obs_bd[c] !== exp_d[c / 3 - 1]) begin
                    errors++;
                    $display("FAIL absdiff_write cycle %0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                             c, obs_ba[c], obs_bd[c], c / 3 - 1, exp_d[c / 3 - 1]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_b_addr !== 2'd3 || o_b_wr_data !== 8'd254) begin
            errors++;
            $display("FAIL absdiff_after: busy=%b done=%b b_addr=%0d b_wr_data=%0d, required 0 0 3 254",
                     o_busy, o_done, o_b_addr, o_b_wr_data);
        end
    endtask

    task automatic test_sum;
        logic [7:0] exp_d [0:3];
        int nwe;
        mem_a[0] = 8'd200; mem_a[1] = 8'd100; mem_a[2] = 8'd128; mem_a[3] = 8'd128;
        mem_a[4] = 8'd1;   mem_a[5] = 8'd255; mem_a[6] = 8'd0;   mem_a[7] = 8'd0;
        exp_d[0] = 8'd44; exp_d[1] = 8'd0; exp_d[2] = 8'd0; exp_d[3] = 8'd0;
        run_cycles(1'b1, 1'b0, 13, 0);
        nwe = 0;
        for (int c = 1; c <= 13; c++) begin
            if (obs_we[c] === 1'b1) nwe++;
        end
        checks++;
        if (nwe != 4) begin
            errors++;
            $display("FAIL sum_we_count: got %0d, required 4", nwe);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_we[3 + 3 * k] !== 1'b1 || obs_bd[3 + 3 * k] !== exp_d[k] || obs_ba[3 + 3 * k] !== 2'(k)) begin
                errors++;
                $display("FAIL sum_write pair %0d: we=%b addr=%0d data=%0d, required 1 %0d %0d",
                         k, obs_we[3 + 3 * k], obs_ba[3 + 3 * k], obs_bd[3 + 3 * k], k, exp_d[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_held;
        int ndone;
        int nwe;
        run_cycles(1'b0, 1'b1, 14, 0);
        ndone = 0;
        nwe   = 0;
        for (int c = 1; c <= 14; c++) begin
            if (obs_done[c] === 1'b1) ndone++;
            if (obs_we[c] === 1'b1) nwe++;
        end
        checks++;
        if (ndone != 1 || obs_done[13] !== 1'b1) begin
            errors++;
            $display("FAIL held_done: count=%0d done13=%b, required 1 and 1", ndone, obs_done[13]);
        end
        checks++;
        if (nwe != 4) begin
            errors++;
            $display("FAIL held_we_count: got %0d, required 4", nwe);
        end
        checks++;
        if (obs_busy[14] !== 1'b0) begin
            errors++;
            $display("FAIL held_busy14: got %b, required 0", obs_busy[14]);
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL held_stays_idle: busy=%b, required 0", o_busy);
        end
    endtask

    task automatic test_reset_mid;
        int nwe;
        run_cycles(1'b0, 1'b0, 14, 7);
        checks++;
        if (obs_we[3] !== 1'b1 || obs_we[6] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_early_writes: we3=%b we6=%b, required 1 1", obs_we[3], obs_we[6]);
        end
        checks++;
        if ({obs_aa[8], obs_ba[8], obs_bd[8], obs_we[8], obs_busy[8], obs_done[8]} !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_cycle8: a_addr=%0d b_addr=%0d b_wr_data=%0d we=%b busy=%b done=%b, required all 0",
                     obs_aa[8], obs_ba[8], obs_bd[8], obs_we[8], obs_busy[8], obs_done[8]);
        end
        nwe = 0;
        for (int c = 8; c <= 14; c++) begin
            if (obs_we[c] !== 1'b0 || obs_done[c] !== 1'b0) nwe++;
        end
        checks++;
        if (nwe != 0) begin
            errors++;
            $display("FAIL rstmid_no_later_writes: %0d active cycles, required 0", nwe);
        end
    endtask

    task automatic test_back_to_back;
        mem_a[0] = 8'd10;  mem_a[1] = 8'd3; mem_a[2] = 8'd5; mem_a[3] = 8'd9;
        mem_a[4] = 8'd0;   mem_a[5] = 8'd0; mem_a[6] = 8'd255; mem_a[7] = 8'd1;
        run_cycles(1'b0, 1'b0, 13, 0);
        checks++;
        if (obs_bd[3] !== 8'd7 || obs_done[13] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: data=%0d done=%b, required 7 1", obs_bd[3], obs_done[13]);
        end
        @(negedge clk);
        run_cycles(1'b1, 1'b0, 13, 0);
        checks++;
        if (obs_busy[1] !== 1'b1 || obs_aa[1] !== 3'd0 || obs_aa[2] !== 3'd1) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b a_addr1=%0d a_addr2=%0d, required 1 0 1", obs_busy[1], obs_aa[1], obs_aa[2]);
        end
        checks++;
        if (obs_bd[3] !== 8'd13 || obs_bd[6] !== 8'd14 || obs_bd[9] !== 8'd0 || obs_bd[12] !== 8'd0) begin
            errors++;
            $display("FAIL b2b_sums: got %0d %0d %0d %0d, required 13 14 0 0", obs_bd[3], obs_bd[6], obs_bd[9], obs_bd[12]);
        end
        checks++;
        if (obs_done[13] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got %b, required 1", obs_done[13]);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic       md;
        logic [7:0] ed;
        int         gap;
        for (int p = 0; p < 200; p++) begin
            for (int i = 0; i < 8; i++) mem_a[i] = 8'($urandom_range(0, 255));
            md = 1'($urandom_range(0, 1));
            run_cycles(md, 1'b0, 13, 0);
            for (int c = 1; c <= 13; c++) begin
                checks++;
                if (obs_we[c] !== (c % 3 == 0 && c <= 12) || obs_done[c] !== (c == 13) || obs_busy[c] !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_ctrl pass %0d cycle %0d: we=%b done=%b busy=%b", p, c, obs_we[c], obs_done[c], obs_busy[c]);
                end
                if (c % 3 == 0 && c <= 12) begin
                    ed = model_res(mem_a[2 * (c / 3 - 1)], mem_a[2 * (c / 3 - 1) + 1], md);
                    checks++;
                    if (obs_ba[c] !== 2'(c / 3 - 1) || obs_bd[c] !== ed) begin
                        errors++;
                        $display("FAIL rand_write pass %0d cycle %0d: addr=%0d data=%0d, required %0d %0d",
                                 p, c, obs_ba[c], obs_bd[c], c / 3 - 1, ed);
                    end
                end
            end
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (o_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle pass %0d: busy=%b, required 0", p, o_busy);
                end
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset   = 1'b1;
        i_start = 1'b0;
        i_mode  = 1'b0;
        for (int i = 0; i < 8; i++) mem_a[i] = 8'd0;
        @(negedge clk);
        test_reset();
        test_absdiff();
        test_sum();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
